// File: rtl/instr_seq_fsm.sv
// Instruction sequencer: walks one opcode through decode, execute,
// write-back and PC increment, with Moore control strobes.
module instr_seq_fsm #(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned OPW         = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  output logic           busy,
  output logic           imm_sel,
  output logic           reg_src_en,
  output logic           alu_en,
  output logic           alu_op,
  output logic           reg_dest_en,
  output logic           pc_inc,
  output logic           done,
  output logic           illegal
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    PCINC  = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [31:0] op_ext;
  logic        is_movi;
  logic        is_mov;
  logic        is_alu;
  logic        is_nop;
  logic        is_ill;

  assign op_ext  = 32'(op_q);
  assign is_movi = (op_ext == 32'd0);
  assign is_mov  = (op_ext == 32'd1);
  assign is_alu  = (op_ext == 32'd2) || (op_ext == 32'd3);
  assign is_nop  = (op_ext == 32'd4);
  assign is_ill  = (op_ext >= 32'd5);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DECODE;
          op_d    = opcode;
        end
      end
      DECODE: begin
        unique case (1'b1)
          is_ill:  state_d = DONE;
          is_nop:  state_d = PCINC;
          default: begin
            state_d = EXEC;
            cnt_d   = CNT_LOAD;
          end
        endcase
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = WB;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WB:      state_d = PCINC;
      PCINC:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes are live through EXEC and WB; the write only in WB.
  logic in_xw;
  assign in_xw = (state_q == EXEC) || (state_q == WB);

  always_comb begin
    busy        = 1'b0;
    imm_sel     = 1'b0;
    reg_src_en  = 1'b0;
    alu_en      = 1'b0;
    alu_op      = 1'b0;
    reg_dest_en = 1'b0;
    pc_inc      = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    busy        = (state_q != IDLE);
    if (in_xw) begin
      imm_sel    = is_movi;
      reg_src_en = is_mov || is_alu;
      alu_en     = is_alu;
      alu_op     = is_alu && op_q[0];
    end
    reg_dest_en = (state_q == WB) && !is_ill && !is_nop;
    pc_inc      = (state_q == PCINC);
    done        = (state_q == DONE);
    illegal     = (state_q == DONE) && is_ill;
  end

endmodule

// File: doc/instr_seq_fsm.md
INSTR_SEQ_FSM -- requirements
Module: instr_seq_fsm

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 2: number of EXEC-state cycles per instruction; legal range 1..15.
REQ-002 SHALL have parameter OPW, default 3: opcode width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request to execute opcode; sampled only in IDLE.
REQ-006 SHALL have port opcode  input  OPW  instruction select, captured with start.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port imm_sel  output  1  immediate onto destination bus (MOVI path).
REQ-009 SHALL have port reg_src_en  output  1  source register read enable.
REQ-010 SHALL have port alu_en  output  1  ALU enable.
REQ-011 SHALL have port alu_op  output  1  0 = add, 1 = sub.
REQ-012 SHALL have port reg_dest_en  output  1  destination register write enable.
REQ-013 SHALL have port pc_inc  output  1  program counter increment strobe.
REQ-014 SHALL have port done  output  1  single-cycle completion pulse.
REQ-015 SHALL have port illegal  output  1  high with done when the captured opcode is undefined.

Function
REQ-016 SHALL implement states IDLE, DECODE, EXEC, WB, PCINC, DONE; all outputs SHALL be Moore functions of the state register and the captured opcode.
REQ-017 SHALL, in IDLE with start=1 at a clock edge, capture opcode into op_q and enter DECODE; start=0 stays in IDLE.
REQ-018 SHALL ignore start and opcode in every state other than IDLE, including DONE.
REQ-019 SHALL go DECODE -> EXEC for op_q 0..3, DECODE -> PCINC for op_q 4 (NOP), and DECODE -> DONE for op_q >= 5 (illegal).
REQ-020 SHALL hold EXEC for exactly EXEC_CYCLES cycles using a down-counter loaded to EXEC_CYCLES-1 on DECODE exit, then enter WB.
REQ-021 SHALL sequence WB -> PCINC -> DONE -> IDLE, one cycle each.
REQ-022 SHALL, for op 0 (MOVI), assert imm_sel in EXEC and WB and assert reg_dest_en in WB.
REQ-023 SHALL, for op 1 (MOV), assert reg_src_en in EXEC and WB and assert reg_dest_en in WB.
REQ-024 SHALL, for op 2 (ADD) and op 3 (SUB), assert reg_src_en and alu_en in EXEC and WB, assert reg_dest_en in WB, and drive alu_op = op_q[0] while alu_en=1, else 0.
REQ-025 SHALL assert pc_inc only in PCINC, for one cycle per accepted legal opcode (ops 0..4); illegal opcodes SHALL never assert pc_inc.
REQ-026 SHALL assert done for exactly one cycle in DONE and assert illegal in that same cycle only when op_q >= 5.
REQ-027 SHALL keep all outputs other than busy at 0 in IDLE and DECODE.
REQ-028 SHALL give latency from start-accept edge to done high of 4+EXEC_CYCLES cycles for ops 0..3, 3 cycles for NOP, and 2 cycles for illegal.
REQ-029 SHALL produce at most one of imm_sel or reg_src_en per instruction, and reg_dest_en only in WB.

Reset
REQ-030 SHALL, when reset=0 at a rising clk edge, force state=IDLE, op_q=0 and counter=0, so that all outputs are 0 from the next cycle onward.
REQ-031 SHALL, on reset mid-instruction, abort with no done, pc_inc or reg_dest_en pulse afterward, and accept a new start in the first cycle after reset releases.

Verification
REQ-032 SHALL cover: EXEC_CYCLES=2, start with opcode=0 -> imm_sel high 3 cycles, reg_dest_en 1 cycle (WB), pc_inc 1 cycle, done 6 cycles after accept, illegal=0.
REQ-033 SHALL cover: opcode=3, EXEC_CYCLES=1 -> alu_en and alu_op=1 for 2 cycles, reg_dest_en 1 cycle, done 5 cycles after accept.
REQ-034 SHALL cover: opcode=4 -> only pc_inc then done, 3 cycles; opcode=7 -> done with illegal=1 after 2 cycles and no pc_inc.
REQ-035 SHALL cover: start held high continuously with opcode changing mid-instruction -> captured opcode is used, the next instruction starts only after returning to IDLE, and there is exactly one done per instruction.
REQ-036 SHALL cover: reset=0 in EXEC -> IDLE next cycle, all outputs 0, no done; start after release -> normal sequence.
